flag_branch_unit: RTL and testbench

- Sits directly downstream of the execute-stage ALU and consumes its FLAGS output {N,V,Z}.
- Owns the architectural NVZ flag register and applies per-opcode write masks.
- Resolves conditional branches (B/BR) in decode, bypassing flags that are being written the same cycle.
- Generates a one-cycle fetch-flush pulse and keeps a saturating taken-branch counter.

---
 rtl/flag_branch_unit_pkg.sv | 44 ++++
 rtl/flag_branch_unit_branch_cond_eval.sv | 34 +++
 rtl/flag_branch_unit.sv | 103 ++++++++++
 tb/tb_flag_branch_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/flag_branch_unit_pkg.sv
// Shared opcode, condition-code and flag-index definitions for the
// flag/branch logic that sits behind the execute-stage ALU.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_NVZ  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// Combinational branch condition evaluation on {N,V,Z} flags.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond
);

  logic n;
  logic v;
  logic z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    cond = 1'b0;
    unique case (ccc)
      CC_NEQ:    cond = ~z;
      CC_EQ:     cond = z;
      CC_GT:     cond = ~z & ~n;
      CC_LT:     cond = n;
      // Z | (~Z & ~N) reduces to Z | ~N
      CC_GTE:    cond = z | ~n;
      CC_LTE:    cond = n | z;
      CC_OVFL:   cond = v;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural NVZ flag register with same-cycle bypass into decode-stage
// branch resolution, a one-cycle fetch flush and a saturating taken counter.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       alu_flags,
  input  logic             id_br_valid,
  input  logic [2:0]       id_ccc,
  input  logic             id_stall,
  output logic [2:0]       flags_q,
  output logic             br_taken,
  output logic             if_flush,
  output logic [CNT_W-1:0] br_count
);

  function automatic logic [2:0] flag_wmask(input logic [3:0] op);
    logic [2:0] m;
    m = MASK_NONE;
    unique case (op)
      OP_ADD, OP_SUB:          m = MASK_NVZ;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:          m = MASK_Z;
      default:                 m = MASK_NONE;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] flag_merge(input logic [2:0] old_f,
                                            input logic [2:0] new_f,
                                            input logic [2:0] mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  fsm_state_t state;
  logic [2:0] wmask;
  logic       fwe;
  logic [2:0] eff_flags;
  logic       br_req;
  logic       cond;

  // Execute side: write enable and bypassed flag view
  always_comb begin
    wmask     = flag_wmask(ex_opcode);
    fwe       = ex_valid & ~ex_stall & (|wmask);
    eff_flags = fwe ? flag_merge(flags_q, alu_flags, wmask) : flags_q;
  end

  branch_cond_eval u_cond (
    .ccc   (id_ccc),
    .flags (eff_flags),
    .cond  (cond)
  );

  // Decode side: the slot behind a taken branch is wrong-path while flushing
  always_comb begin
    br_req   = id_br_valid & ~id_stall & (state == ST_IDLE);
    br_taken = ~rst & br_req & cond;
  end

  // Registered state: flags, flush FSM and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= 3'b000;
      state    <= ST_IDLE;
      if_flush <= 1'b0;
      br_count <= '0;
    end else begin
      if (fwe)
        flags_q <= eff_flags;
      unique case (state)
        ST_IDLE: begin
          if (br_taken) begin
            state    <= ST_FLUSH;
            if_flush <= 1'b1;
            br_count <= sat_inc(br_count);
          end else begin
            if_flush <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state    <= ST_IDLE;
          if_flush <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          if_flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed vector bench for flag_branch_unit; a narrow-counter instance
// shares the stimulus so counter saturation is reachable quickly.
module tb_flag_branch_unit;

  localparam int SAT_W = 4;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic             ex_stall;
  logic [3:0]       ex_opcode;
  logic [2:0]       alu_flags;
  logic             id_br_valid;
  logic [2:0]       id_ccc;
  logic             id_stall;
  logic [2:0]       flags_q;
  logic             br_taken;
  logic             if_flush;
  logic [15:0]      br_count;
  logic [2:0]       flags_q_s;
  logic             br_taken_s;
  logic             if_flush_s;
  logic [SAT_W-1:0] br_count_s;

  int errors = 0;
  int checks = 0;

  flag_branch_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .alu_flags(alu_flags), .id_br_valid(id_br_valid),
    .id_ccc(id_ccc), .id_stall(id_stall), .flags_q(flags_q),
    .br_taken(br_taken), .if_flush(if_flush), .br_count(br_count)
  );

  flag_branch_unit #(.CNT_W(SAT_W)) dut_s (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_opcode(ex_opcode), .alu_flags(alu_flags), .id_br_valid(id_br_valid),
    .id_ccc(id_ccc), .id_stall(id_stall), .flags_q(flags_q_s),
    .br_taken(br_taken_s), .if_flush(if_flush_s), .br_count(br_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       exv;
    logic       exs;
    logic [3:0] op;
    logic [2:0] alu;
    logic       brv;
    logic [2:0] ccc;
    logic       ids;
    logic       tk;
    logic [2:0] fl;
    logic       fs;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic exv, logic exs,
                              logic [3:0] op, logic [2:0] alu, logic brv,
                              logic [2:0] ccc, logic ids, logic tk,
                              logic [2:0] fl, logic fs, int cnt);
    vec_t v;
    v.name = name; v.rst = r; v.exv = exv; v.exs = exs; v.op = op;
    v.alu = alu; v.brv = brv; v.ccc = ccc; v.ids = ids; v.tk = tk;
    v.fl = fl; v.fs = fs; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle: check combinational decision, then registered results.
  task automatic apply(vec_t v);
    int exp_s;
    rst = v.rst; ex_valid = v.exv; ex_stall = v.exs; ex_opcode = v.op;
    alu_flags = v.alu; id_br_valid = v.brv; id_ccc = v.ccc; id_stall = v.ids;
    #3;
    chk({v.name, ".br_taken"}, int'(br_taken), int'(v.tk));
    chk({v.name, ".br_taken_s"}, int'(br_taken_s), int'(v.tk));
    @(posedge clk);
    #1;
    exp_s = (v.cnt > SAT_MAX) ? SAT_MAX : v.cnt;
    chk({v.name, ".flags_q"}, int'(flags_q), int'(v.fl));
    chk({v.name, ".if_flush"}, int'(if_flush), int'(v.fs));
    chk({v.name, ".br_count"}, int'(br_count), v.cnt);
    chk({v.name, ".br_count_s"}, int'(br_count_s), exp_s);
  endtask

  initial begin
    int   cnt;
    vec_t v;
    string ccname;
    logic [7:0] sweep_tk;

    rst = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0; ex_opcode = 4'b0000;
    alu_flags = 3'b000; id_br_valid = 1'b0; id_ccc = 3'b000; id_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //                name        rst exv exs op       alu     brv ccc     ids tk  fl      fs  cnt
    vecs.push_back(mk("reset",    1, 0, 0, 4'b0000, 3'b000, 1, 3'b111, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk("add111",   0, 1, 0, 4'b0000, 3'b111, 0, 3'b000, 0, 0, 3'b111, 0, 0));
    vecs.push_back(mk("xor000",   0, 1, 0, 4'b0010, 3'b000, 0, 3'b000, 0, 0, 3'b110, 0, 0));
    vecs.push_back(mk("sub000",   0, 1, 0, 4'b0001, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 0));
    vecs.push_back(mk("byp_eq",   0, 1, 0, 4'b0001, 3'b001, 1, 3'b001, 0, 1, 3'b001, 1, 1));
    vecs.push_back(mk("flush1",   0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b001, 0, 1));
    vecs.push_back(mk("add000",   0, 1, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(mk("stl_eq",   0, 1, 1, 4'b0001, 3'b001, 1, 3'b001, 0, 0, 3'b000, 0, 1));
    vecs.push_back(mk("stl_neq",  0, 1, 1, 4'b0001, 3'b001, 1, 3'b000, 0, 1, 3'b000, 1, 2));
    vecs.push_back(mk("gap0",     0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 2));
    vecs.push_back(mk("add100",   0, 1, 0, 4'b0000, 3'b100, 0, 3'b000, 0, 0, 3'b100, 0, 2));

    // Condition sweep with flags 100, an idle gap after each branch
    sweep_tk = 8'b1010_1001;  // bit i = taken for ccc i
    cnt = 2;
    for (int i = 0; i < 8; i++) begin
      ccname = $sformatf("cc%0d", i);
      if (sweep_tk[i]) cnt++;
      vecs.push_back(mk(ccname, 0, 0, 0, 4'b0000, 3'b000, 1, 3'(i), 0,
                        sweep_tk[i], 3'b100, sweep_tk[i], cnt));
      vecs.push_back(mk({ccname, "_gap"}, 0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0,
                        0, 3'b100, 0, cnt));
    end

    vecs.push_back(mk("b2b_1",    0, 0, 0, 4'b0000, 3'b000, 1, 3'b111, 0, 1, 3'b100, 1, 7));
    vecs.push_back(mk("b2b_2",    0, 0, 0, 4'b0000, 3'b000, 1, 3'b111, 0, 0, 3'b100, 0, 7));
    vecs.push_back(mk("b2b_gap",  0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b100, 0, 7));
    vecs.push_back(mk("idstall",  0, 1, 0, 4'b0000, 3'b001, 1, 3'b111, 1, 0, 3'b001, 0, 7));
    vecs.push_back(mk("lw_nowr",  0, 1, 0, 4'b1000, 3'b111, 0, 3'b000, 0, 0, 3'b001, 0, 7));
    vecs.push_back(mk("sra_z",    0, 1, 0, 4'b0101, 3'b110, 0, 3'b000, 0, 0, 3'b000, 0, 7));
    vecs.push_back(mk("exinval",  0, 0, 0, 4'b0000, 3'b111, 0, 3'b000, 0, 0, 3'b000, 0, 7));
    vecs.push_back(mk("ror_z",    0, 1, 0, 4'b0110, 3'b001, 0, 3'b000, 0, 0, 3'b001, 0, 7));
    vecs.push_back(mk("br_nowr",  0, 1, 0, 4'b1101, 3'b110, 1, 3'b001, 0, 1, 3'b001, 1, 8));
    vecs.push_back(mk("br_gap",   0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b001, 0, 8));

    foreach (vecs[i]) apply(vecs[i]);

    // Drive the narrow counter into saturation with UNCOND on alternate cycles
    cnt = 8;
    for (int i = 0; i < 10; i++) begin
      cnt++;
      v = mk($sformatf("sat%0d", i), 0, 0, 0, 4'b0000, 3'b000, 1, 3'b111, 0,
             1, 3'b001, 1, cnt);
      apply(v);
      v = mk($sformatf("sat%0d_gap", i), 0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0,
             0, 3'b001, 0, cnt);
      apply(v);
    end

    // Reset arriving while flushing clears everything on the next edge
    v = mk("pre_rst", 0, 0, 0, 4'b0000, 3'b000, 1, 3'b111, 0, 1, 3'b001, 1, cnt + 1);
    apply(v);
    v = mk("rst_fl", 1, 1, 0, 4'b0000, 3'b111, 1, 3'b111, 0, 0, 3'b000, 0, 0);
    apply(v);
    v = mk("post_rst", 0, 0, 0, 4'b0000, 3'b000, 0, 3'b000, 0, 0, 3'b000, 0, 0);
    apply(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
